pc_flow_ctrl: RTL
=================

# pc_flow_ctrl

Sequencer that drives the PC bank (8-frame PC stack with per-frame increment/set and frame-pointer inc/dec) from decoded control-flow requests. Converts NEXT/JUMP/BRANCH/CALL/RET requests into correctly ordered pc_inc / pc_ref_inc / pc_ref_dec / pc_set pulses. Keeps a shadow frame depth so stack overflow and underflow are caught and refused before they reach the bank. Sits between the instruction decoder and the PC bank.

## Interface
- No parameters; widths fixed: PC 9 bits, depth 3 bits (8 frames).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  decoder presents a request.
- req_op  in  3  0 NOP, 1 NEXT, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6-7 treated as NOP.
- req_target  in  9  jump/branch/call target.
- req_cond  in  1  BRANCH taken when 1; ignored for other ops.
- req_ready  out  1  request accepted on an edge where req_valid & req_ready.
- fault_clr  in  1  single-cycle pulse; leaves FAULT.
- pc_inc, pc_ref_inc, pc_ref_dec, pc_set  out  1 each  command pulses to the PC bank.
- pc_set_value  out  9  value written on pc_set.
- depth  out  3  current frame index (mirror of bank frame pointer).
- fault  out  1  sticky overflow/underflow flag.

## Operation
- States: IDLE, CALL_SET, FAULT. req_ready = (state == IDLE).
- All command outputs and pc_set_value are registered; each is a one-cycle pulse, at most one issue cycle per accepted request step.
- On acceptance in IDLE:
  - NOP / op 6-7: no command.
  - NEXT: pc_inc.
  - JUMP: pc_set, pc_set_value = req_target.
  - BRANCH: req_cond=1 -> pc_set with req_target; req_cond=0 -> pc_inc.
  - CALL, depth < 7: pc_inc and pc_ref_inc together (return address pc+1 saved in current frame, pointer advances); target latched; depth+1; -> CALL_SET.
  - CALL, depth == 7: no command; fault <= 1; -> FAULT.
  - RET, depth > 0: pc_ref_dec (caller frame already holds return address); depth-1.
  - RET, depth == 0: no command; fault <= 1; -> FAULT.
- CALL_SET: issue pc_set with latched target on the new frame; -> IDLE unconditionally.
- FAULT: no commands, req_ready = 0, depth frozen; fault_clr -> IDLE and fault <= 0. fault_clr ignored in other states.
- pc_inc and pc_set never asserted in the same cycle; pc_ref_inc and pc_ref_dec never asserted together; pc_set never asserted with a pointer change.
- depth never wraps; bank error input is never provoked by this block.

## Timing
- Reset (rst low, asynchronous): state IDLE, depth 0, fault 0, all command pulses 0, pc_set_value 0, req_ready 1 after deassertion. Reset mid-CALL discards the pending pc_set.
- Acceptance at edge N -> command pulse high during cycle N+1 (sampled by bank at edge N+1).
- Single-step ops: back-to-back, one request per cycle.
- CALL: accept edge N; pc_inc+pc_ref_inc in cycle N+1; pc_set in cycle N+2; req_ready low in cycle N+1, high in N+2 (next request's command earliest in N+3).
- Fault: detected at accepting edge N; fault high from cycle N+1; clears the cycle after the edge sampling fault_clr; req_ready high that same cycle.
- req_target/req_cond sampled only at the accepting edge.

## Test plan
- Reset, then NEXT x3 back-to-back -> pc_inc pulses in 3 consecutive cycles; bank PC 0->3; depth 0.
- JUMP target 0x1A0, then BRANCH cond=0, then BRANCH cond=1 target 0x005 -> pc_set 0x1A0, pc_inc, pc_set 0x005; bank PC ends 0x005.
- PC=0x010, CALL target 0x080 -> cycle N+1 pc_inc+pc_ref_inc, cycle N+2 pc_set 0x080, req_ready low one cycle; depth 1; RET -> pc_ref_dec, bank PC 0x011, depth 0.
- 7 CALLs to depth 7, 8th CALL -> no commands, fault=1, req_ready=0; NEXT held valid not accepted; fault_clr -> IDLE, depth 7, fault 0.
- RET at depth 0 -> fault=1, no pc_ref_dec; bank err stays 0.
- Assert rst low in cycle N+1 of a CALL -> no pc_set in N+2; after release depth 0, fault 0, outputs 0, req_ready 1.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: turns decoded control-flow requests into ordered command
// pulses for the 8-frame PC bank, tracking frame depth to refuse stack
// overflow/underflow before it reaches the bank.
module pc_flow_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    input  logic [8:0] req_target,
    input  logic       req_cond,
    output logic       req_ready,
    input  logic       fault_clr,
    output logic       pc_inc,
    output logic       pc_ref_inc,
    output logic       pc_ref_dec,
    output logic       pc_set,
    output logic [8:0] pc_set_value,
    output logic [2:0] depth,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE,
        CALL_SET,
        FAULT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_NEXT   = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_t;

    state_t     state, state_n;
    logic [8:0] target, target_n;
    logic [2:0] depth_n;
    logic       fault_n;
    logic       inc_n, ref_inc_n, ref_dec_n, set_n;
    logic [8:0] set_value_n;

    assign req_ready = (state == IDLE);

    // Register state, shadow depth, latched call target and command pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            target       <= '0;
            depth        <= '0;
            fault        <= 1'b0;
            pc_inc       <= 1'b0;
            pc_ref_inc   <= 1'b0;
            pc_ref_dec   <= 1'b0;
            pc_set       <= 1'b0;
            pc_set_value <= '0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            depth        <= depth_n;
            fault        <= fault_n;
            pc_inc       <= inc_n;
            pc_ref_inc   <= ref_inc_n;
            pc_ref_dec   <= ref_dec_n;
            pc_set       <= set_n;
            pc_set_value <= set_value_n;
        end
    end

    // Decode accepted requests into next state and next command pulses.
    always_comb begin
        state_n     = state;
        target_n    = target;
        depth_n     = depth;
        fault_n     = fault;
        inc_n       = 1'b0;
        ref_inc_n   = 1'b0;
        ref_dec_n   = 1'b0;
        set_n       = 1'b0;
        set_value_n = pc_set_value;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_NEXT: inc_n = 1'b1;
                        OP_JUMP: begin
                            set_n       = 1'b1;
                            set_value_n = req_target;
                        end
                        OP_BRANCH: begin
                            if (req_cond) begin
                                set_n       = 1'b1;
                                set_value_n = req_target;
                            end else begin
                                inc_n = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            if (depth != 3'd7) begin
                                // Return address saved by the increment on the
                                // caller frame; the jump lands on the new frame
                                // in the following cycle.
                                inc_n     = 1'b1;
                                ref_inc_n = 1'b1;
                                target_n  = req_target;
                                depth_n   = depth + 3'd1;
                                state_n   = CALL_SET;
                            end else begin
                                fault_n = 1'b1;
                                state_n = FAULT;
                            end
                        end
                        OP_RET: begin
                            if (depth != 3'd0) begin
                                ref_dec_n = 1'b1;
                                depth_n   = depth - 3'd1;
                            end else begin
                                fault_n = 1'b1;
                                state_n = FAULT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALL_SET: begin
                set_n       = 1'b1;
                set_value_n = target;
                state_n     = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    fault_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
